// File: rtl/store_merge_if.sv
// rtl/store_merge_if.sv - store request and memory bus bundle for store_merge
interface store_merge_if;
  logic        start;
  logic [1:0]  SM_CS;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_wr;
  logic [31:0] mem_wdata;

  modport slave (
    input  start, SM_CS, addr, data_in, mem_rdata,
    output busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output start, SM_CS, addr, data_in, mem_rdata,
    input  busy, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/store_merge.sv
// rtl/store_merge.sv - sub-word store via read-modify-write of the containing word
module store_merge (
  input  logic          clk,
  input  logic          rst,
  store_merge_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, FIN, ERR} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  cs_q, cs_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic        misaligned;
  logic        sub_word;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cs_d        = cs_q;
    mem_wdata_d = mem_wdata_q;
    sub_word    = (bus.SM_CS == 2'b01) || (bus.SM_CS == 2'b10);

    case (bus.SM_CS)
      2'b01:   misaligned = bus.addr[0];
      2'b10:   misaligned = 1'b0;
      default: misaligned = |bus.addr[1:0];
    endcase

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d = bus.addr;
          data_d = bus.data_in;
          cs_d   = bus.SM_CS;
          if (misaligned) begin
            state_d = ERR;
          end else if (sub_word) begin
            state_d = READ;
          end else begin
            state_d     = WRITE;
            mem_wdata_d = bus.data_in;
          end
        end
      end
      READ: state_d = CAPT;
      CAPT: begin
        // Overlay the new lane(s) onto the word fetched during READ.
        mem_wdata_d = bus.mem_rdata;
        case (cs_q)
          2'b10:   mem_wdata_d[{addr_q[1:0], 3'b000} +: 8]  = data_q[7:0];
          2'b01:   mem_wdata_d[{addr_q[1], 4'b0000} +: 16]  = data_q[15:0];
          default: mem_wdata_d = data_q;
        endcase
        state_d = WRITE;
      end
      WRITE:   state_d = FIN;
      FIN:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d != IDLE);
    done_d   = (state_d == FIN) || (state_d == ERR);
    err_d    = (state_d == ERR);
    mem_rd_d = (state_d == READ);
    mem_wr_d = (state_d == WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      cs_q        <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cs_q        <= cs_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
endmodule

// File: tb/tb_store_merge.sv
// tb/tb_store_merge.sv - randomized and directed self-checking bench for store_merge
module tb_store_merge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_merge_if ifc();
  store_merge dut (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct {
    bit          busy, done, err, rd, wr, chk_addr, chk_wdata;
    logic [31:0] addr, wdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0, errors = 0, cyc = 0, t0 = 0;
  int          rd_count, wr_count, done_count;
  int          rd_first, rd_last, wr_first, wr_last, done_first, done_last;
  logic [31:0] wr_addr, wr_data;
  logic        err_at_done;
  bit          rd_prev = 1'b0;
  logic [31:0] rd_addr_prev = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return {wa[15:0], ~wa[15:0]};
  endfunction

  function automatic exp_t mk(input bit b, d, e, r, w, ca, cw, input logic [31:0] a, wd);
    exp_t x;
    x.busy = b; x.done = d; x.err = e; x.rd = r; x.wr = w;
    x.chk_addr = ca; x.chk_wdata = cw; x.addr = a; x.wdata = wd;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Expected per-cycle outputs of one store, derived from its size and alignment.
  task automatic push_txn(input logic [1:0] cs, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] wa, w;
    bit half, byt, word, mis;
    int k;
    half = (cs == 2'b01);
    byt  = (cs == 2'b10);
    word = !half && !byt;
    wa   = {a[31:2], 2'b00};
    mis  = (half && a[0]) || (word && (a[1:0] != 2'b00));
    if (mis) begin
      exp_q.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
    end else if (word) begin
      exp_q.push_back(mk(1, 0, 0, 0, 1, 1, 1, wa, d));
      exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    end else begin
      w = mem_word(wa);
      if (byt) begin
        k = int'(a[1:0]);
        w[8*k +: 8] = d[7:0];
      end else begin
        k = int'(a[1]);
        w[16*k +: 16] = d[15:0];
      end
      exp_q.push_back(mk(1, 0, 0, 1, 0, 1, 0, wa, 0));
      exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, wa, 0));
      exp_q.push_back(mk(1, 0, 0, 0, 1, 1, 1, wa, w));
      exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic model_edge();
    exp_t e;
    bit idle;
    if (rst) begin
      exp_q.delete();
      return;
    end
    idle = (exp_q.size() == 0);
    if (!idle) begin
      e = exp_q.pop_front();
      if (e.wr) mem[e.addr] = e.wdata;
    end
    if (idle && ifc.start) push_txn(ifc.SM_CS, ifc.addr, ifc.data_in);
  endtask

  task automatic compare();
    exp_t e;
    int rel;
    chk("rd_wr_exclusive", {31'd0, ifc.mem_rd & ifc.mem_wr}, 0);
    if (rst) begin
      chk("rst_busy", ifc.busy, 0);
      chk("rst_done", ifc.done, 0);
      chk("rst_err", ifc.err, 0);
      chk("rst_mem_rd", ifc.mem_rd, 0);
      chk("rst_mem_wr", ifc.mem_wr, 0);
      chk("rst_mem_addr", ifc.mem_addr, 0);
      chk("rst_mem_wdata", ifc.mem_wdata, 0);
    end else if (exp_q.size() == 0) begin
      chk("idle_busy", ifc.busy, 0);
      chk("idle_done", ifc.done, 0);
      chk("idle_err", ifc.err, 0);
      chk("idle_mem_rd", ifc.mem_rd, 0);
      chk("idle_mem_wr", ifc.mem_wr, 0);
    end else begin
      e = exp_q[0];
      chk("busy", ifc.busy, e.busy);
      chk("done", ifc.done, e.done);
      chk("err", ifc.err, e.err);
      chk("mem_rd", ifc.mem_rd, e.rd);
      chk("mem_wr", ifc.mem_wr, e.wr);
      if (e.chk_addr) chk("mem_addr", ifc.mem_addr, e.addr);
      if (e.chk_wdata) chk("mem_wdata", ifc.mem_wdata, e.wdata);
    end
    rel = cyc - t0;
    if (ifc.mem_rd) begin
      rd_count++;
      if (rd_first < 0) rd_first = rel;
      rd_last = rel;
    end
    if (ifc.mem_wr) begin
      wr_count++;
      if (wr_first < 0) wr_first = rel;
      wr_last = rel;
      wr_addr = ifc.mem_addr;
      wr_data = ifc.mem_wdata;
    end
    if (ifc.done) begin
      done_count++;
      if (done_first < 0) done_first = rel;
      done_last = rel;
      err_at_done = ifc.err;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    compare();
    // Memory responder: data for a read appears the cycle after mem_rd.
    if (rd_prev) ifc.mem_rdata = mem_word(rd_addr_prev);
    else ifc.mem_rdata = $urandom;
    rd_prev = ifc.mem_rd && !rst;
    rd_addr_prev = ifc.mem_addr;
  endtask

  task automatic clear_ev();
    t0 = cyc;
    rd_count = 0; wr_count = 0; done_count = 0;
    rd_first = -1; rd_last = -1; wr_first = -1; wr_last = -1;
    done_first = -1; done_last = -1;
    wr_addr = '0; wr_data = '0; err_at_done = 1'b0;
  endtask

  task automatic txn(input logic [1:0] cs, input logic [31:0] a, input logic [31:0] d);
    clear_ev();
    ifc.start = 1'b1; ifc.SM_CS = cs; ifc.addr = a; ifc.data_in = d;
    step();
    ifc.start = 1'b0;
    for (int i = 0; i < 8 && done_count == 0; i++) step();
    if (done_count == 0) chk("txn_timeout", 0, 1);
    step();
  endtask

  initial begin
    ifc.start = 1'b0; ifc.SM_CS = 2'b00; ifc.addr = '0; ifc.data_in = '0; ifc.mem_rdata = '0;
    clear_ev();
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    mem[32'h100] = 32'h11223344;
    mem[32'h200] = 32'hCAFE1234;

    txn(2'b10, 32'h103, 32'h000000AB);
    chk("sb_rd_cycle", rd_first, 1);
    chk("sb_rd_count", rd_count, 1);
    chk("sb_wr_cycle", wr_first, 3);
    chk("sb_wr_addr", wr_addr, 32'h100);
    chk("sb_wr_data", wr_data, 32'hAB223344);
    chk("sb_done_cycle", done_first, 4);
    chk("sb_err", err_at_done, 0);

    txn(2'b01, 32'h202, 32'h0000BEEF);
    chk("sh_wr_data", wr_data, 32'hBEEF1234);
    chk("sh_wr_count", wr_count, 1);
    chk("sh_done_cycle", done_first, 4);

    txn(2'b00, 32'h40, 32'hDEADBEEF);
    chk("sw_rd_count", rd_count, 0);
    chk("sw_wr_cycle", wr_first, 1);
    chk("sw_wr_data", wr_data, 32'hDEADBEEF);
    chk("sw_wr_addr", wr_addr, 32'h40);
    chk("sw_done_cycle", done_first, 2);

    txn(2'b11, 32'h80, 32'h0BADF00D);
    chk("rsv_done_cycle", done_first, 2);
    chk("rsv_wr_data", wr_data, 32'h0BADF00D);

    txn(2'b10, 32'h100, 32'h00000055);
    chk("sb_lane0_data", wr_data, 32'hAB223355);

    txn(2'b01, 32'h201, 32'h0000BEEF);
    chk("mis_sh_done_cycle", done_first, 1);
    chk("mis_sh_err", err_at_done, 1);
    chk("mis_sh_rdwr", rd_count + wr_count, 0);

    txn(2'b00, 32'h42, 32'h12345678);
    chk("mis_sw_done_cycle", done_first, 1);
    chk("mis_sw_err", err_at_done, 1);
    chk("mis_sw_rdwr", rd_count + wr_count, 0);

    clear_ev();
    ifc.start = 1'b1; ifc.SM_CS = 2'b10; ifc.addr = 32'h301; ifc.data_in = 32'h77;
    step();
    ifc.start = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("abort_busy", ifc.busy, 0);
    chk("abort_mem_addr", ifc.mem_addr, 0);
    chk("abort_mem_wdata", ifc.mem_wdata, 0);
    chk("abort_mem_rd", ifc.mem_rd, 0);
    step();
    rst = 1'b0;
    chk("abort_no_wr", wr_count, 0);
    txn(2'b00, 32'h300, 32'h600DCAFE);
    chk("post_rst_done_cycle", done_first, 2);
    chk("post_rst_wr_data", wr_data, 32'h600DCAFE);

    clear_ev();
    ifc.start = 1'b1; ifc.SM_CS = 2'b10; ifc.addr = 32'h103; ifc.data_in = 32'hCD;
    repeat (10) step();
    ifc.start = 1'b0;
    repeat (2) step();
    chk("held_wr_count", wr_count, 2);
    chk("held_done_first", done_first, 4);
    chk("held_rd_last", rd_last, 6);
    chk("held_done_last", done_last, 9);

    for (int i = 0; i < 4000; i++) begin
      ifc.start   = ($urandom_range(0, 2) == 0);
      ifc.SM_CS   = 2'($urandom_range(0, 3));
      ifc.addr    = 32'h1000 | (32'($urandom_range(0, 7)) << 2)
                    | ($urandom_range(0, 1) != 0 ? 32'($urandom_range(0, 3)) : 32'd0);
      ifc.data_in = $urandom;
      rst         = !rst && ($urandom_range(0, 199) == 0);
      step();
    end
    ifc.start = 1'b0;
    rst = 1'b0;
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_merge.md
STORE_MERGE -- requirements
Module: store_merge

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, store request; sampled only in IDLE.
REQ-004 SHALL have port SM_CS, input, 2, store size: 00 = word (sw), 01 = halfword (sh), 10 = byte (sb), 11 = reserved, treated as word.
REQ-005 SHALL have port addr, input, 32, byte address of the store.
REQ-006 SHALL have port data_in, input, 32, store data; sh uses [15:0], sb uses [7:0].
REQ-007 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port err, output, 1, one-cycle misalignment pulse, coincident with done.
REQ-010 SHALL have port mem_addr, output, 32, word address {addr_q[31:2], 2'b00}.
REQ-011 SHALL have port mem_rd, output, 1, memory read strobe.
REQ-012 SHALL have port mem_rdata, input, 32, read data, valid the cycle after mem_rd is high.
REQ-013 SHALL have port mem_wr, output, 1, memory write strobe, one cycle per store.
REQ-014 SHALL have port mem_wdata, output, 32, full merged word to write.

Function
REQ-015 SHALL be an FSM with states IDLE, READ, CAPT, WRITE, FIN and ERR; all outputs registered (driven from state and internal registers only).
REQ-016 SHALL, in IDLE with start=1, latch addr, data_in and SM_CS into addr_q, data_q and cs_q.
REQ-017 SHALL, in IDLE with start=1, go to ERR if misaligned (halfword with addr[0]=1; word or reserved with addr[1:0]!=0).
REQ-018 SHALL, in IDLE with start=1 and aligned word or reserved size, go to WRITE with mem_wdata=data_in (no read).
REQ-019 SHALL, in IDLE with start=1 and aligned byte or halfword, go to READ.
REQ-020 SHALL ignore start outside IDLE; a request held high is accepted again only on return to IDLE.
REQ-021 SHALL hold mem_rd=1 for exactly the READ cycle, then go to CAPT.
REQ-022 SHALL, in CAPT, capture mem_rdata and form mem_wdata, then go to WRITE:
  - byte: lane k=addr_q[1:0], bits [8k+7:8k] = data_q[7:0];
  - halfword: h=addr_q[1], bits [16h+15:16h] = data_q[15:0];
  - all other bits equal to the read word (little-endian lanes).
REQ-023 SHALL hold mem_wr=1 for exactly the WRITE cycle, with mem_addr and mem_wdata stable, then go to FIN.
REQ-024 SHALL, in FIN, pulse done=1 with err=0, then return to IDLE.
REQ-025 SHALL, in ERR, pulse done=1 and err=1 with no mem_rd or mem_wr, then return to IDLE.
REQ-026 SHALL keep mem_addr valid from READ through WRITE.
REQ-027 SHALL keep mem_rd and mem_wr mutually exclusive at all times.
REQ-028 SHALL have latency start-to-done of 5 cycles for byte/halfword, 3 cycles for word and 2 cycles for misaligned.
REQ-029 SHALL assert busy for those same durations minus one (busy low in IDLE only).
REQ-030 SHALL allow back-to-back stores: start may be accepted in the cycle after done.

Reset
REQ-031 SHALL, on rst=1 at any time including mid-operation, asynchronously force IDLE.
REQ-032 SHALL, on rst=1, clear busy, done, err, mem_rd, mem_wr, mem_addr, mem_wdata and all latched registers to 0.
REQ-033 SHALL NOT issue a write after a reset occurring in READ or CAPT; any latched request is discarded.
REQ-034 SHALL accept start in the first clock edge after rst deasserts.

Verification
REQ-035 sb: addr=0x103, data_in=0x000000AB, mem_rdata=0x11223344 -> mem_rd at cycle 1, mem_wr at cycle 3 with mem_addr=0x100, mem_wdata=0xAB223344, done at cycle 4.
REQ-036 sh: addr=0x202, data_in=0x0000BEEF, mem_rdata=0xCAFE1234 -> mem_wdata=0xBEEF1234, single mem_wr.
REQ-037 sw: addr=0x40, data_in=0xDEADBEEF -> no mem_rd; mem_wr at cycle 1 with mem_wdata=0xDEADBEEF; done at cycle 2.
REQ-038 Misaligned sh at addr=0x201, and sw at addr=0x42 -> err=done=1 one cycle after start; mem_rd=mem_wr=0 throughout.
REQ-039 rst pulsed during CAPT of an sb -> all outputs 0 immediately; no mem_wr; a new sw accepted after release completes normally.
REQ-040 start held high across two sb requests -> second accepted only in the cycle after the first done; exactly two mem_wr pulses.
